instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word-aligned fetches, buffers in-order responses
// with their PCs, and presents them to decode; redirects flush in-flight responses.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode,
  output logic [2:0]  if_funct3,
  output logic [6:0]  if_funct7
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     pc_reg, pc_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   buf_count_reg, buf_count_next;
  logic [PW-1:0]   buf_head_reg, buf_head_next;
  logic [PW-1:0]   buf_tail_reg, buf_tail_next;
  logic [PW-1:0]   addr_head_reg, addr_tail_reg;

  logic [31:0]     buf_instr_mem [BUF_DEPTH];
  logic [31:0]     buf_pc_mem    [BUF_DEPTH];
  logic [31:0]     addr_mem      [BUF_DEPTH];

  logic            req_accept;
  logic            rsp_take;
  logic            buf_push;
  logic            buf_pop;
  logic [CW:0]     occupancy;
  logic            unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  // Issue only when every outstanding request already owns a buffer slot.
  assign occupancy      = {1'b0, inflight_reg} + {1'b0, buf_count_reg};
  assign imem_req_valid = (state_reg == FETCH) && (occupancy < DEPTH_W) && !redirect_valid;
  assign imem_req_addr  = pc_reg;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && (inflight_reg != '0);
  assign buf_push       = rsp_take && (state_reg == FETCH) && !redirect_valid;
  assign if_valid       = (buf_count_reg != '0);
  assign buf_pop        = if_valid && if_ready;

  assign if_pc     = if_valid ? buf_pc_mem[buf_head_reg]    : 32'h0;
  assign if_instr  = if_valid ? buf_instr_mem[buf_head_reg] : 32'h0;
  assign if_opcode = if_instr[6:0];
  assign if_funct3 = if_instr[14:12];
  assign if_funct7 = if_instr[31:25];

  always_comb begin
    inflight_next = inflight_reg;
    if (req_accept && !rsp_take) begin
      inflight_next = inflight_reg + CW'(1);
    end else if (!req_accept && rsp_take) begin
      inflight_next = inflight_reg - CW'(1);
    end

    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (req_accept) begin
      pc_next = pc_reg + 32'd4;
    end

    buf_head_next  = buf_head_reg;
    buf_tail_next  = buf_tail_reg;
    buf_count_next = buf_count_reg;
    // A same-cycle pop still completes; the clear simply supersedes it.
    if (redirect_valid) begin
      buf_head_next  = '0;
      buf_tail_next  = '0;
      buf_count_next = '0;
    end else begin
      if (buf_push) buf_tail_next = buf_tail_reg + PW'(1);
      if (buf_pop)  buf_head_next = buf_head_reg + PW'(1);
      case ({buf_push, buf_pop})
        2'b10:   buf_count_next = buf_count_reg + CW'(1);
        2'b01:   buf_count_next = buf_count_reg - CW'(1);
        default: buf_count_next = buf_count_reg;
      endcase
    end

    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   if (redirect_valid && (inflight_next != '0)) state_next = FLUSH;
      FLUSH:   if (!redirect_valid && (inflight_next == '0)) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      inflight_reg  <= '0;
      buf_count_reg <= '0;
      buf_head_reg  <= '0;
      buf_tail_reg  <= '0;
      addr_head_reg <= '0;
      addr_tail_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      inflight_reg  <= inflight_next;
      buf_count_reg <= buf_count_next;
      buf_head_reg  <= buf_head_next;
      buf_tail_reg  <= buf_tail_next;
      // Address FIFO survives redirects so discarded responses stay aligned.
      if (req_accept) addr_tail_reg <= addr_tail_reg + PW'(1);
      if (rsp_take)   addr_head_reg <= addr_head_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_accept) begin
      addr_mem[addr_tail_reg] <= pc_reg;
    end
    if (buf_push) begin
      buf_instr_mem[buf_tail_reg] <= imem_rsp_data;
      buf_pc_mem[buf_tail_reg]    <= addr_mem[addr_head_reg];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: randomized in-order memory model and a
// stream scoreboard expecting sequential PCs from reset / each redirect target.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic [2:0]  if_funct3;
  logic [6:0]  if_funct7;

  instruction_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_opcode(if_opcode), .if_funct3(if_funct3), .if_funct7(if_funct7)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  int          n_checks, n_pass;
  int          cyc;
  mreq_t       mq[$];
  int          last_due;
  int          lat_min, lat_max;
  int          outstanding;
  logic [31:0] exp_pc, exp_req;
  bit          hold_pending, chk_empty, flushing;
  logic [31:0] hold_addr;
  logic [31:0] acc_log[$];
  int          first_acc, first_valid;
  int          n_pop;
  logic [31:0] last_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // One clock of observation: scoreboard at negedge, memory drive after posedge.
  task automatic step();
    logic acc, hs, rsp;
    logic [31:0] w;
    int out_next, due;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    hs  = if_valid && if_ready;
    rsp = imem_rsp_valid;
    if (chk_empty) begin
      n_checks++;
      if (if_valid !== 1'b0) $display("FAIL flush_empty: if_valid got %b expected 0", if_valid);
      else n_pass++;
      chk_empty = 0;
    end
    if (hold_pending && !redirect_valid) begin
      n_checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, hold_addr})
        $display("FAIL req_hold: got v=%b a=%h expected v=1 a=%h", imem_req_valid, imem_req_addr, hold_addr);
      else n_pass++;
    end
    if (redirect_valid || flushing) begin
      n_checks++;
      if (imem_req_valid !== 1'b0) $display("FAIL req_quiet: imem_req_valid got %b expected 0", imem_req_valid);
      else n_pass++;
    end
    if (imem_req_valid) begin
      n_checks++;
      if (imem_req_addr !== exp_req) $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_req);
      else n_pass++;
    end
    if (hs) begin
      w = mem_word(exp_pc);
      n_checks++;
      if (if_pc !== exp_pc) $display("FAIL if_pc: got %h expected %h", if_pc, exp_pc);
      else n_pass++;
      n_checks++;
      if (if_instr !== w) $display("FAIL if_instr: got %h expected %h", if_instr, w);
      else n_pass++;
      n_checks++;
      if ({if_opcode, if_funct3, if_funct7} !== {w[6:0], w[14:12], w[31:25]})
        $display("FAIL if_fields: got %h/%h/%h expected %h/%h/%h",
                 if_opcode, if_funct3, if_funct7, w[6:0], w[14:12], w[31:25]);
      else n_pass++;
      $display("pop  cyc=%0d pc=%h instr=%h", cyc, if_pc, if_instr);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
      last_pop_pc = if_pc;
    end
    if (!if_valid) begin
      n_checks++;
      if ({if_pc, if_instr} !== 64'h0) $display("FAIL empty_zero: got pc=%h instr=%h expected 0/0", if_pc, if_instr);
      else n_pass++;
    end
    out_next = outstanding + (acc ? 1 : 0) - (rsp ? 1 : 0);
    n_checks++;
    if (out_next > DEPTH || out_next < 0) $display("FAIL inflight_bound: got %0d expected 0..%0d", out_next, DEPTH);
    else n_pass++;
    if (acc) begin
      if (first_acc < 0) first_acc = cyc;
      acc_log.push_back(imem_req_addr);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem_req_addr, due: due});
      exp_req = exp_req + 32'd4;
    end
    if (if_valid && first_valid < 0) first_valid = cyc;
    hold_pending = imem_req_valid && !imem_req_ready;
    hold_addr    = imem_req_addr;
    outstanding  = out_next;
    if (flushing && outstanding == 0) flushing = 0;
    if (redirect_valid) begin
      exp_pc       = {redirect_pc[31:2], 2'b00};
      exp_req      = {redirect_pc[31:2], 2'b00};
      chk_empty    = 1;
      hold_pending = 0;
      flushing     = (outstanding != 0);
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    redirect_valid = 1'b0;
    mq.delete();
    acc_log.delete();
    outstanding = 0; last_due = cyc;
    hold_pending = 0; chk_empty = 0; flushing = 0;
    exp_pc = RST_PC; exp_req = RST_PC;
    first_acc = -1; first_valid = -1;
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b0, RST_PC})
      $display("FAIL reset_req: got v=%b a=%h expected v=0 a=%h", imem_req_valid, imem_req_addr, RST_PC);
    else n_pass++;
    n_checks++;
    if ({if_valid, if_pc, if_instr} !== 65'h0)
      $display("FAIL reset_if: got v=%b pc=%h instr=%h expected 0", if_valid, if_pc, if_instr);
    else n_pass++;
    apply_reset(2);
    n_checks++;
    if (imem_req_valid !== 1'b0) $display("FAIL idle_no_req: got %b expected 0", imem_req_valid);
    else n_pass++;
  endtask

  task automatic test_reset_exit();
    logic [31:0] exp_addrs [5];
    int k;
    exp_addrs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    k = 0;
    while ((acc_log.size() < 5 || first_valid < 0) && k < 40) begin step(); k++; end
    n_checks++;
    if (acc_log.size() < 5) $display("FAIL exit_timeout: got %0d accepts expected 5", acc_log.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (acc_log[i] !== exp_addrs[i]) $display("FAIL wrap_addr%0d: got %h expected %h", i, acc_log[i], exp_addrs[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (first_valid - first_acc != 2) $display("FAIL first_latency: got %0d expected 2", first_valid - first_acc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int p;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; if_ready = 1'b0;
    repeat (10) step();
    n_checks++;
    if ({imem_req_valid, if_valid} !== 2'b01 || outstanding != 0)
      $display("FAIL bp_full: got req_v=%b if_v=%b out=%0d expected 0/1/0", imem_req_valid, if_valid, outstanding);
    else n_pass++;
    p = n_pop;
    if_ready = 1'b1;
    step(); step();
    n_checks++;
    if (n_pop != p + 2) $display("FAIL bp_drain: got %0d pops expected 2", n_pop - p);
    else n_pass++;
    repeat (10) step();
  endtask

  task automatic test_redirect_flush();
    int k, p, a;
    lat_min = 3; lat_max = 3;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    k = 0;
    while (outstanding != 2 && k < 30) begin step(); k++; end
    n_checks++;
    if (outstanding != 2) $display("FAIL flush_setup: got %0d in flight expected 2", outstanding);
    else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    p = n_pop; a = acc_log.size(); k = 0;
    while (acc_log.size() == a && k < 30) begin step(); k++; end
    n_checks++;
    if (acc_log.size() == a || acc_log[$] !== 32'h100)
      $display("FAIL flush_next_addr: got %h expected 00000100", (acc_log.size() == a) ? 32'hX : acc_log[$]);
    else n_pass++;
    k = 0;
    while (n_pop == p && k < 30) begin step(); k++; end
    n_checks++;
    if (n_pop == p || last_pop_pc !== 32'h100) $display("FAIL flush_next_pc: got %h expected 00000100", last_pop_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_unaligned();
    int k, a;
    lat_min = 1; lat_max = 2;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    a = acc_log.size(); k = 0;
    while (acc_log.size() == a && k < 30) begin step(); k++; end
    n_checks++;
    if (acc_log.size() == a || acc_log[$] !== 32'h200)
      $display("FAIL align_addr: got %h expected 00000200", (acc_log.size() == a) ? 32'hX : acc_log[$]);
    else n_pass++;
    repeat (6) step();
  endtask

  task automatic test_redirect_collide();
    int k, p;
    bit hit;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1;
    hit = 0; k = 0;
    while (!hit && k < 60) begin
      if (imem_rsp_valid && if_valid) begin
        hit = 1;
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = $urandom & 32'hFFFF_FFFC;
        p = n_pop;
        step();
        n_checks++;
        if (n_pop != p + 1) $display("FAIL collide_pop: got %0d pops expected 1", n_pop - p);
        else n_pass++;
      end else begin
        if_ready = ($urandom_range(1, 0) == 1);
        step();
      end
      k++;
    end
    n_checks++;
    if (!hit) $display("FAIL collide_timeout: got no rsp+valid cycle expected one");
    else n_pass++;
    if_ready = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_random();
    bit prev;
    int p;
    prev = 0; p = n_pop;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready = ($urandom_range(9, 0) < 7);
      if (!prev && $urandom_range(29, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
        prev = 1;
      end else prev = 0;
      step();
    end
    n_checks++;
    if (n_pop <= p) $display("FAIL random_progress: got %0d pops expected >0", n_pop - p);
    else n_pass++;
  endtask

  task automatic test_reset_midburst();
    int k;
    lat_min = 1; lat_max = 3;
    imem_req_ready = 1'b1; if_ready = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr} !== {1'b0, RST_PC, 1'b0, 64'h0})
      $display("FAIL async_reset: got v=%b a=%h if_v=%b pc=%h instr=%h expected reset values",
               imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr);
    else n_pass++;
    apply_reset(3);
    if_ready = 1'b1;
    k = 0;
    while (acc_log.size() == 0 && k < 20) begin step(); k++; end
    n_checks++;
    if (acc_log.size() == 0 || acc_log[0] !== RST_PC)
      $display("FAIL restart_addr: got %h expected %h", (acc_log.size() == 0) ? 32'hX : acc_log[0], RST_PC);
    else n_pass++;
    repeat (10) step();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; n_pop = 0; last_pop_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    lat_min = 1; lat_max = 1;
    test_reset();
    test_reset_exit();
    test_backpressure();
    test_redirect_flush();
    test_redirect_unaligned();
    test_redirect_collide();
    test_random();
    test_reset_midburst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
